// File: rtl/if_rf_ctrl_pkg.sv
// Shared types and constants for the IF/RF pipeline control unit.
package if_rf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_FREEZE       = 2'd1,
    ST_FREEZE_FLUSH = 2'd2
  } ctrl_state_e;

  // Register 31 reads as zero, so it can never carry a load-use dependency.
  localparam int unsigned XZR = 31;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_rf_ctrl.sv
// IF/RF stage control: advance/hold/flush decisions, load-use bubbles,
// branch flushes deferred across data-memory freezes, and event counters.
//
// state           | meaning
// ST_RUN          | pipeline flowing, no deferred work
// ST_FREEZE       | memory freeze, nothing pending
// ST_FREEZE_FLUSH | memory freeze, taken branch waiting to flush IF/RF
module if_rf_ctrl
  import if_rf_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] rf_rn,
  input  logic [REG_W-1:0] rf_rm,
  input  logic             rf_uses_rm,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             if_rf_en,
  output logic             if_rf_flush,
  output logic             id_ex_bubble,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_e state_q, state_d;
  logic        hazard;
  logic        stall_inc;

  assign hazard = ex_mem_read
                  && (ex_rd != REG_W'(XZR))
                  && ((ex_rd == rf_rn) || (rf_uses_rm && (ex_rd == rf_rm)));

  // Outputs are combinational so the PC/IF-RF enables act in the same cycle.
  always_comb begin
    pc_we        = 1'b0;
    if_rf_en     = 1'b0;
    if_rf_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    freeze       = 1'b0;
    state_d      = ST_RUN;
    if (reset) begin
      if (mem_busy) begin
        freeze = 1'b1;
        if ((state_q == ST_FREEZE_FLUSH)
            || ((state_q == ST_RUN) && br_taken && !hazard)) begin
          state_d = ST_FREEZE_FLUSH;
        end else begin
          state_d = ST_FREEZE;
        end
      end else if (hazard) begin
        // Branch operands are not ready yet, so br_taken is ignored here.
        id_ex_bubble = 1'b1;
      end else begin
        pc_we       = 1'b1;
        if_rf_en    = 1'b1;
        if_rf_flush = br_taken || (state_q == ST_FREEZE_FLUSH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign stall_inc = reset && !pc_we;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_rf_flush),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_if_rf_ctrl.sv
// Scoreboard bench for if_rf_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the control rules.
module tb_if_rf_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             reset;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd, rf_rn, rf_rm;
  logic             rf_uses_rm, br_taken, mem_busy, cnt_clr;
  logic             pc_we, if_rf_en, if_rf_flush, id_ex_bubble, freeze;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  if_rf_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .rf_rn        (rf_rn),
    .rf_rm        (rf_rm),
    .rf_uses_rm   (rf_uses_rm),
    .br_taken     (br_taken),
    .mem_busy     (mem_busy),
    .cnt_clr      (cnt_clr),
    .pc_we        (pc_we),
    .if_rf_en     (if_rf_en),
    .if_rf_flush  (if_rf_flush),
    .id_ex_bubble (id_ex_bubble),
    .freeze       (freeze),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             pc_we, en, flush, bubble, frz;
    logic [CNT_W-1:0] sc, fc;
    int               step;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   step_no = 0;

  // Reference model: a frozen flag plus a pending-branch flag, and plain counts.
  bit   m_frozen = 0;
  bit   m_pending = 0;
  int   m_sc = 0;
  int   m_fc = 0;

  task automatic apply(input bit rst, input bit emr, input int erd, input int rn,
                       input int rm, input bit urm, input bit br, input bit busy,
                       input bit clr);
    exp_t e;
    bit   hz;
    reset = rst; ex_mem_read = emr; ex_rd = REG_W'(erd); rf_rn = REG_W'(rn);
    rf_rm = REG_W'(rm); rf_uses_rm = urm; br_taken = br; mem_busy = busy; cnt_clr = clr;
    hz = emr && (erd != 31) && ((erd == rn) || (urm && (erd == rm)));
    e.pc_we = 0; e.en = 0; e.flush = 0; e.bubble = 0; e.frz = 0;
    e.sc = CNT_W'(m_sc); e.fc = CNT_W'(m_fc); e.step = step_no;
    if (!rst) begin
      m_frozen = 0; m_pending = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (busy) begin
        e.frz = 1;
        m_pending = m_pending || (!m_frozen && br && !hz);
        m_frozen = 1;
      end else if (hz) begin
        e.bubble = 1;
        m_pending = 0; m_frozen = 0;
      end else begin
        e.pc_we = 1; e.en = 1;
        e.flush = br || m_pending;
        m_pending = 0; m_frozen = 0;
      end
      if (clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (!e.pc_we && m_sc < int'(CNT_MAX)) m_sc++;
        if (e.flush && m_fc < int'(CNT_MAX)) m_fc++;
      end
    end
    exp_q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rst);
    apply(rst, 0, 0, 1, 2, 1, 0, 0, 0);
  endtask

  task automatic check(input string name, input int step, input int act, input int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        check("pc_we",        e.step, int'(pc_we),        int'(e.pc_we));
        check("if_rf_en",     e.step, int'(if_rf_en),     int'(e.en));
        check("if_rf_flush",  e.step, int'(if_rf_flush),  int'(e.flush));
        check("id_ex_bubble", e.step, int'(id_ex_bubble), int'(e.bubble));
        check("freeze",       e.step, int'(freeze),       int'(e.frz));
        check("stall_cnt",    e.step, int'(stall_cnt),    int'(e.sc));
        check("flush_cnt",    e.step, int'(flush_cnt),    int'(e.fc));
      end
    end
  end

  initial begin
    int r[4];
    int drain;
    reset = 0; ex_mem_read = 0; ex_rd = '0; rf_rn = '0; rf_rm = '0;
    rf_uses_rm = 0; br_taken = 0; mem_busy = 0; cnt_clr = 0;
    // First edge establishes a known state before anything is scored.
    @(posedge clk);
    #1;
    m_frozen = 0; m_pending = 0; m_sc = 0; m_fc = 0;

    idle(0); idle(0);
    idle(1); idle(1);
    // load-use with a taken branch: bubble, branch ignored
    apply(1, 1, 5, 5, 0, 0, 1, 0, 0);
    idle(1);
    // XZR never stalls
    apply(1, 1, 31, 31, 31, 1, 0, 0, 0);
    // unused Rm never stalls
    apply(1, 1, 7, 3, 7, 0, 0, 0, 0);
    apply(1, 1, 7, 3, 7, 1, 0, 0, 0);
    idle(1);
    // branch deferred by a 3-cycle freeze, flushed on release
    apply(1, 0, 0, 1, 2, 1, 1, 1, 0);
    apply(1, 0, 0, 1, 2, 1, 1, 1, 0);
    apply(1, 0, 0, 1, 2, 1, 1, 1, 0);
    idle(1); idle(1);
    // reset during a pending flush discards it
    apply(1, 0, 0, 1, 2, 1, 1, 1, 0);
    apply(1, 0, 0, 1, 2, 1, 0, 1, 0);
    idle(0);
    idle(1); idle(1);
    // saturate stall_cnt, then clear together with a stall
    for (int i = 0; i < 20; i++) apply(1, 1, 9, 9, 0, 0, 0, 0, 0);
    apply(1, 1, 9, 9, 0, 0, 0, 0, 1);
    idle(1);

    r[0] = 5; r[1] = 7; r[2] = 31;
    for (int i = 0; i < 3000; i++) begin
      int erd, rn, rm;
      r[3] = int'($urandom_range(0, 31));
      erd = r[$urandom_range(0, 3)];
      rn  = r[$urandom_range(0, 3)];
      rm  = r[$urandom_range(0, 3)];
      apply(($urandom_range(0, 49) != 0), $urandom_range(0, 1), erd, rn, rm,
            $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_rf_ctrl.md
# if_rf_ctrl

Pipeline control unit for the IF/RF stage register of the pipelined LEGv8 core. It decides each cycle whether the PC and IF/RF register advance, hold, or are flushed, and whether a bubble is injected into RF/EX. It also tracks branch flushes that are deferred by data-memory freezes, and keeps saturating stall and flush event counters. It sits beside the hazard and forwarding logic and drives the PC write enable and the IF/RF enable and flush controls.

## Interface
- REG_W, 5: register-number width.
- CNT_W, 32: event-counter width.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low.
- ex_mem_read  in  1  instruction in EX is a load (LDUR).
- ex_rd  in  REG_W  destination register of the EX instruction.
- rf_rn  in  REG_W  Rn of the instruction in RF.
- rf_rm  in  REG_W  Rm (or Rt for stores/CBZ) of the instruction in RF.
- rf_uses_rm  in  1  RF instruction reads rf_rm.
- br_taken  in  1  branch in RF resolved taken this cycle.
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
- cnt_clr  in  1  clear both counters.
- pc_we  out  1  PC register load enable.
- if_rf_en  out  1  IF/RF register load enable.
- if_rf_flush  out  1  IF/RF loads 32'h0 (bubble) instead of fetched instruction.
- id_ex_bubble  out  1  RF/EX control fields loaded as NOP.
- freeze  out  1  hold RF/EX, EX/MEM and MEM/WB.
- stall_cnt  out  CNT_W  cycles with pc_we=0 since last clear.
- flush_cnt  out  CNT_W  cycles with if_rf_flush=1 since last clear.

## Operation
- States: RUN, FREEZE, FREEZE_FLUSH (freeze with a pending branch flush).
- hazard = ex_mem_read & (ex_rd != 31) & ((ex_rd == rf_rn) | (rf_uses_rm & ex_rd == rf_rm)). XZR (31) never causes a hazard.
- Priority: mem_busy > hazard > br_taken.
- mem_busy=1, any state:
  - Outputs: pc_we=0, if_rf_en=0, freeze=1, if_rf_flush=0, id_ex_bubble=0.
  - Next state is FREEZE_FLUSH if already FREEZE_FLUSH, or if in RUN with br_taken & !hazard.
  - Otherwise next state is FREEZE.
- mem_busy=0, no hazard:
  - Outputs: pc_we=1, if_rf_en=1, freeze=0, id_ex_bubble=0.
  - if_rf_flush = br_taken | (state==FREEZE_FLUSH).
  - Next state RUN.
- mem_busy=0, hazard:
  - Outputs: pc_we=0, if_rf_en=0, id_ex_bubble=1, if_rf_flush=0; br_taken is ignored because the branch operands are not ready.
  - Next state RUN.
  - A pending flush from FREEZE_FLUSH cannot coincide with a hazard; no special handling is needed.
- Counters:
  - Both counters saturate at all-ones.
  - stall_cnt increments when pc_we=0 and reset=1.
  - flush_cnt increments when if_rf_flush=1.
  - cnt_clr zeroes both counters, and wins over an increment in the same cycle.

## Timing
- All control outputs are combinational from the current state and inputs within the same cycle; state and counters register on posedge clk.
- While reset=0: all control outputs are 0 and neither counter increments.
- At the first edge with reset=0: state becomes RUN and both counters become 0.
- A load-use stall lasts exactly one cycle with no freeze: the bubble advances and ex_mem_read drops.
- A branch deferred by a freeze is flushed on the first cycle with mem_busy=0, then the block returns to RUN.
- If reset is asserted during a freeze, the pending flush is discarded.

## Structure
- Shared package if_rf_ctrl_pkg holds:
  - the state enum type (RUN, FREEZE, FREEZE_FLUSH);
  - the XZR constant (31).
- Sub-module sat_counter (parameter W; inputs inc and clr; output count), instantiated twice.
- The FSM and the hazard compare are inline in if_rf_ctrl.

## Test plan
- Reset held 2 cycles, then released -> every control output is 0 during reset; afterwards pc_we=1, if_rf_en=1; stall_cnt=0, flush_cnt=0.
- ex_mem_read=1, ex_rd=5, rf_rn=5, br_taken=1 -> one cycle of pc_we=0, id_ex_bubble=1, if_rf_flush=0; stall_cnt=1.
- ex_mem_read=1, ex_rd=31, rf_rn=31 -> no stall.
- rf_uses_rm=0, rf_rm=ex_rd -> no stall.
- br_taken=1 together with mem_busy=1 for 3 cycles, then mem_busy=0 -> freeze=1 for 3 cycles; if_rf_flush=1 on cycle 4; flush_cnt=1; stall_cnt=3.
- Reset asserted while in FREEZE_FLUSH -> after release, if_rf_flush=0.
- stall_cnt preloaded to all-ones by 2^CNT_W stalls (use CNT_W=4) -> stays 4'hF; cnt_clr together with a stall -> count becomes 0.
